rst_release_sequencer: RTL
==========================

Name: rst_release_sequencer

Overview:
- Reset-distribution block that generates the resets consumed by the team's synchronous-reset flops.
- Takes the raw asynchronous active-high board reset and synchronizes its deassertion: assert is asynchronous, release is synchronous.
- Holds for a guard interval, then releases N downstream reset domains one after another, each separated by a fixed gap.
- Also accepts a software reset request while running and replays the full sequence.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for reset deassertion; must be >= 2.
- N_STAGES, 4, number of sequenced reset outputs; must be >= 1.
- HOLD_CYCLES, 16, guard cycles between synchronized release and release of stage 0; must be >= 1.
- STAGE_GAP, 4, cycles between successive stage releases; must be >= 1.
- SW_PULSE, 8, cycles all stages are held in reset after an accepted software request; must be >= 1.

Ports:
- clk_i  input  1  single clock for the whole block.
- rst_i  input  1  asynchronous active-high reset; one clock, async active-high reset, as already decided.
- sw_rst_req_i  input  1  software reset request; level-sampled, honoured only in RUN.
- rst_sync_o  output  1  synchronized reset; asserts asynchronously with rst_i, deasserts SYNC_STAGES rising edges after rst_i falls.
- stage_rst_o  output  N_STAGES  per-domain active-high resets; bit k is released before bit k+1.
- rst_done_o  output  1  high when every stage is released (state RUN).
- sw_rst_ack_o  output  1  one-cycle pulse when a software request is accepted.

Behaviour:
- rst_i high, applied asynchronously with no clock needed:
  - synchronizer flops, rst_sync_o and stage_rst_o are all ones.
  - rst_done_o=0, sw_rst_ack_o=0, FSM=HOLD, counters=0.
- Synchronizer:
  - shifts 0 in on each rising edge while rst_i is low.
  - rst_sync_o is the last flop; it falls on the SYNC_STAGES-th rising edge after rst_i falls.
- FSM states: HOLD, RELEASE, RUN, SWRST. All state flops use async reset on rst_i.
- Any state, rst_sync_o=1: FSM forced to HOLD, cnt=0, stage index=0, all stage_rst_o=1.
- HOLD:
  - cnt increments each cycle while rst_sync_o=0.
  - At cnt==HOLD_CYCLES-1, the same edge clears stage_rst_o[0], goes to RELEASE, and sets cnt=0, idx=1.
  - Result: stage_rst_o[0] falls exactly HOLD_CYCLES edges after rst_sync_o falls.
- RELEASE:
  - At cnt==STAGE_GAP-1, clear stage_rst_o[idx], idx++, cnt=0; otherwise cnt++.
  - The edge that clears bit N_STAGES-1 also sets rst_done_o=1 and goes to RUN.
  - N_STAGES==1: go straight from HOLD to RUN, with rst_done_o rising together with stage 0.
  - Stage k falls HOLD_CYCLES + k*STAGE_GAP edges after rst_sync_o falls.
- RUN: if sw_rst_req_i=1 at an edge, that same edge does all of the following:
  - sets every stage_rst_o bit to 1;
  - clears rst_done_o;
  - pulses sw_rst_ack_o high for exactly one cycle;
  - moves to SWRST with cnt=0.
- SWRST:
  - counts SW_PULSE cycles, then goes to HOLD with cnt=0, and the full HOLD/RELEASE sequence repeats.
  - rst_sync_o is unaffected by software reset.
- sw_rst_req_i outside RUN: ignored, no ack, no latching. If it is still high when RUN is re-entered, it is accepted on the first RUN edge.
- Stage bits only ever deassert in index order. No bit is released while a lower-index bit is still in reset.
- rst_i mid-sequence (any state): immediate asynchronous return to the reset values above. Counters never wrap; each is sized to the largest of HOLD_CYCLES, STAGE_GAP and SW_PULSE.

Optional Feature:
- Macro: RST_SEQ_CAUSE_EN.
- Defined: adds port rst_cause_o (output, 2 bits).
  - Reset value 2'b01 (hardware reset).
  - Set to 2'b10 on the edge that accepts a software request.
  - Holds its value through the following sequence and RUN.
  - Returns to 2'b01 only on rst_i.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults; rst_i high 5 cycles, then low -> rst_sync_o falls on 2nd edge. stage_rst_o bits 0..3 fall 16/20/24/28 edges after that. rst_done_o rises with bit 3. Bits never release out of order.
- In RUN, pulse sw_rst_req_i for 1 cycle -> next edge: stage_rst_o=4'b1111, rst_done_o=0, sw_rst_ack_o high for 1 cycle. After 8 cycles, re-sequence with the same 16/20/24/28 offsets; rst_sync_o stays 0.
- Assert rst_i asynchronously mid-RELEASE (bits 0,1 released) -> all outputs return to reset values with no clock edge. Release rst_i -> full sequence restarts from the synchronizer.
- Hold sw_rst_req_i high continuously from HOLD -> no ack until RUN. Ack on the first RUN edge, then one ack per completed sequence.
- N_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1 -> stage_rst_o[0] and rst_done_o rise/fall on the first edge after rst_sync_o falls.
- RST_SEQ_CAUSE_EN defined -> rst_cause_o=01 after rst_i, 10 after an accepted sw request, 01 again after a new rst_i.

Source files
------------

// File: rtl/rst_release_sequencer.sv
// rst_release_sequencer
// Reset-distribution block: synchronizes the release of the raw board reset,
// waits a guard interval, then releases N_STAGES downstream reset domains in
// index order with a fixed gap between them. A software request accepted in
// RUN re-asserts every domain for SW_PULSE cycles and replays the sequence.
// Optional build macro RST_SEQ_CAUSE_EN adds rst_cause_o (01 = hardware
// reset, 10 = software reset).
module rst_release_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int SW_PULSE    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sw_rst_req_i,
    output logic                rst_sync_o,
    output logic [N_STAGES-1:0] stage_rst_o,
    output logic                rst_done_o,
    output logic                sw_rst_ack_o
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [1:0]          rst_cause_o
`endif
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > SW_PULSE) ? CNT_MAX_A : SW_PULSE;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W     = $clog2(N_STAGES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_SWRST
    } seqState_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_syncRst;

    seqState_t              r_state;
    seqState_t              w_stateNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idxNext;
    logic [N_STAGES-1:0]    r_stage;
    logic [N_STAGES-1:0]    w_stageNext;
    logic                   r_done;
    logic                   w_doneNext;
    logic                   r_ack;
    logic                   w_ackNext;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0]             r_cause;
    logic [1:0]             w_causeNext;
`endif

    // Reset synchronizer: asserts with rst_i, releases after SYNC_STAGES edges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign w_syncRst = r_sync[SYNC_STAGES-1];

    // Sequencer state register; every flop returns to its reset value on rst_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stage <= '1;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_idx   <= w_idxNext;
            r_stage <= w_stageNext;
            r_done  <= w_doneNext;
            r_ack   <= w_ackNext;
        end
    end

`ifdef RST_SEQ_CAUSE_EN
    // Reset-cause register: only a hardware reset brings it back to 01
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cause <= 2'b01;
        end else begin
            r_cause <= w_causeNext;
        end
    end
`endif

    // Next-state logic: guard hold, in-order stage release, run, software pulse
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_idxNext   = r_idx;
        w_stageNext = r_stage;
        w_doneNext  = r_done;
        w_ackNext   = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
        w_causeNext = r_cause;
`endif
        if (w_syncRst) begin
            w_stateNext = ST_HOLD;
            w_cntNext   = '0;
            w_idxNext   = '0;
            w_stageNext = '1;
            w_doneNext  = 1'b0;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_stageNext[0] = 1'b0;
                        w_cntNext      = '0;
                        w_idxNext      = IDX_W'(1);
                        if (N_STAGES == 1) begin
                            w_stateNext = ST_RUN;
                            w_doneNext  = 1'b1;
                        end else begin
                            w_stateNext = ST_RELEASE;
                        end
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        for (int k = 0; k < N_STAGES; k++) begin
                            if (IDX_W'(k) == r_idx) begin
                                w_stageNext[k] = 1'b0;
                            end
                        end
                        w_cntNext = '0;
                        w_idxNext = r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST) begin
                            w_stateNext = ST_RUN;
                            w_doneNext  = 1'b1;
                        end
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req_i) begin
                        w_stageNext = '1;
                        w_doneNext  = 1'b0;
                        w_ackNext   = 1'b1;
                        w_cntNext   = '0;
                        w_stateNext = ST_SWRST;
`ifdef RST_SEQ_CAUSE_EN
                        w_causeNext = 2'b10;
`endif
                    end
                end
                ST_SWRST: begin
                    if (r_cnt == SW_LAST) begin
                        w_stateNext = ST_HOLD;
                        w_cntNext   = '0;
                        w_idxNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_stateNext = ST_HOLD;
                    w_cntNext   = '0;
                    w_idxNext   = '0;
                    w_stageNext = '1;
                    w_doneNext  = 1'b0;
                end
            endcase
        end
    end

    assign rst_sync_o   = w_syncRst;
    assign stage_rst_o  = r_stage;
    assign rst_done_o   = r_done;
    assign sw_rst_ack_o = r_ack;
`ifdef RST_SEQ_CAUSE_EN
    assign rst_cause_o  = r_cause;
`endif

endmodule
